// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - 5-stage pipeline hazard controller with multi-cycle execute and memory-wait stalls
module hazard_unit_mc #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              rs1_used_d,
  input  logic              rs2_used_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              reg_write_e,
  input  logic              load_e,
  input  logic              md_op_e,
  input  logic              pc_src_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic              dmem_ready_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_count
);

  // Countdown width covers MD_LATENCY-2; at least one bit even when the FSM is unused.
  localparam int            CW        = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_START = CW'((MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0);
  localparam bit            MD_EN     = (MD_LATENCY > 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic mem_stall;
  logic md_stall;
  logic lw_stall;
  logic fsm_busy;

  // While reset is held the FSM is treated as idle and memory waits are ignored.
  assign mem_stall = !rst && !dmem_ready_m;
  assign fsm_busy  = !rst && (state_q == BUSY);
  assign md_stall  = MD_EN && !rst &&
                     (((state_q == IDLE) && md_op_e) || ((state_q == BUSY) && (cnt_q != '0)));
  assign lw_stall  = load_e && reg_write_e && (rd_e != '0) &&
                     ((rs1_used_d && (rs1_d == rd_e)) || (rs2_used_d && (rs2_d == rd_e)));

  assign md_busy     = fsm_busy;
  assign stall_count = stall_count_q;

  // State, countdown and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Next state: a memory wait freezes the multi-cycle op exactly where it is.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (MD_EN && md_op_e && !mem_stall) begin
        state_d = BUSY;
        cnt_d   = CNT_START;
      end
    end else begin
      if (!mem_stall) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // Stall counter next value, holding at all-ones instead of wrapping.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_f && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Stall/flush outputs by priority: memory wait, then multi-cycle op, then load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (mem_stall) begin
      // Whole front of the pipe freezes; a resolved branch is retried later.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      if (md_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      if (pc_src_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Operand forwarding: M beats W, x0 is never forwarded.
  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    if ((rs1_e != '0) && reg_write_m && (rs1_e == rd_m)) begin
      forward_a_e = 2'b10;
    end else if ((rs1_e != '0) && reg_write_w && (rs1_e == rd_w)) begin
      forward_a_e = 2'b01;
    end
    if ((rs2_e != '0) && reg_write_m && (rs2_e == rd_m)) begin
      forward_b_e = 2'b10;
    end else if ((rs2_e != '0) && reg_write_w && (rs2_e == rd_w)) begin
      forward_b_e = 2'b01;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - randomized and directed check of hazard_unit_mc against a behavioural model
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rs1_used_d, rs2_used_d, reg_write_e, load_e, md_op_e, pc_src_e;
  logic       reg_write_m, dmem_ready_m, reg_write_w;

  logic [1:0]  stall_f, stall_d, stall_e, stall_m;
  logic [1:0]  flush_d, flush_e, flush_m, flush_w, md_busy;
  logic [1:0]  fwd_a0, fwd_b0, fwd_a1, fwd_b1;
  logic [3:0]  sc0;
  logic [15:0] sc1;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Model state: remaining E cycles of the current multi-cycle op (0 = none), stall cycles seen.
  int lat [2]  = '{4, 1};
  int cmax [2] = '{15, 65535};
  int left_m [2];
  int cnt_m [2];
  int sf_run;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(4), .CNT_W(4)) dut_l4 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .load_e(load_e), .md_op_e(md_op_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .dmem_ready_m(dmem_ready_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .stall_f(stall_f[0]), .stall_d(stall_d[0]), .stall_e(stall_e[0]), .stall_m(stall_m[0]),
    .flush_d(flush_d[0]), .flush_e(flush_e[0]), .flush_m(flush_m[0]), .flush_w(flush_w[0]),
    .forward_a_e(fwd_a0), .forward_b_e(fwd_b0), .md_busy(md_busy[0]), .stall_count(sc0)
  );

  hazard_unit_mc #(.REG_AW(5), .MD_LATENCY(1), .CNT_W(16)) dut_l1 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .load_e(load_e), .md_op_e(md_op_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .dmem_ready_m(dmem_ready_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .stall_f(stall_f[1]), .stall_d(stall_d[1]), .stall_e(stall_e[1]), .stall_m(stall_m[1]),
    .flush_d(flush_d[1]), .flush_e(flush_e[1]), .flush_m(flush_m[1]), .flush_w(flush_w[1]),
    .forward_a_e(fwd_a1), .forward_b_e(fwd_b1), .md_busy(md_busy[1]), .stall_count(sc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (rs != 0 && reg_write_m && rs == rd_m) return 2'b10;
    if (rs != 0 && reg_write_w && rs == rd_w) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {stall_f,d,e,m, flush_d,e,m,w, fwd_a, fwd_b, md_busy} for one instance.
  function automatic logic [12:0] model_ctl(input int k);
    bit mem, md, lw, pc, busy;
    mem  = !rst && !dmem_ready_m;
    busy = !rst && left_m[k] > 0;
    md   = !rst && lat[k] > 1 && ((left_m[k] == 0 && md_op_e) || left_m[k] > 1);
    lw   = load_e && reg_write_e && rd_e != 0 &&
           ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
    pc   = pc_src_e;
    return {mem | md | lw, mem | md | lw, mem | md, mem,
            !mem && pc, !mem && (pc || (!md && lw)), !mem && md, mem,
            fwd_ref(rs1_e), fwd_ref(rs2_e), busy};
  endfunction

  // Check current outputs at the falling edge, then clock and advance the model.
  task automatic step();
    logic [12:0] exp_v, got_v;
    bit sf [2];
    bit mem;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_v = model_ctl(k);
      sf[k] = exp_v[12];
      if (k == 0) begin
        got_v = {stall_f[0], stall_d[0], stall_e[0], stall_m[0], flush_d[0], flush_e[0],
                 flush_m[0], flush_w[0], fwd_a0, fwd_b0, md_busy[0]};
        check("ctl_lat4", got_v, exp_v);
        check("count_lat4", sc0, cnt_m[0]);
      end else begin
        got_v = {stall_f[1], stall_d[1], stall_e[1], stall_m[1], flush_d[1], flush_e[1],
                 flush_m[1], flush_w[1], fwd_a1, fwd_b1, md_busy[1]};
        check("ctl_lat1", got_v, exp_v);
        check("count_lat1", sc1, cnt_m[1]);
      end
    end
    if (stall_f[0]) sf_run++;
    mem = !rst && !dmem_ready_m;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        left_m[k] = 0;
        cnt_m[k]  = 0;
      end else begin
        if (sf[k] && cnt_m[k] < cmax[k]) cnt_m[k]++;
        if (!mem) begin
          if (left_m[k] > 0) left_m[k]--;
          else if (md_op_e && lat[k] > 1) left_m[k] = lat[k] - 1;
        end
      end
    end
    #1;
  endtask

  task automatic quiet_inputs();
    rs1_d = 0; rs2_d = 0; rs1_used_d = 0; rs2_used_d = 0;
    rs1_e = 0; rs2_e = 0; rd_e = 0; reg_write_e = 0; load_e = 0;
    md_op_e = 0; pc_src_e = 0; rd_m = 0; reg_write_m = 0;
    dmem_ready_m = 1; rd_w = 0; reg_write_w = 0;
  endtask

  task automatic load_use_setup();
    load_e = 1; reg_write_e = 1; rd_e = 7; rs2_d = 7; rs2_used_d = 1;
  endtask

  initial begin
    quiet_inputs();
    rst = 1;
    left_m = '{0, 0};
    cnt_m  = '{0, 0};
    @(posedge clk);
    #1;
    step();
    step();
    rst = 0;
    step();

    // Forwarding priority and x0 qualification
    rs1_e = 5; rs2_e = 5; rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1;
    #1 check("fwd_a_m", fwd_a0, 2'b10);
    check("fwd_b_m", fwd_b0, 2'b10);
    step();
    reg_write_m = 0;
    #1 check("fwd_a_w", fwd_a0, 2'b01);
    step();
    rs1_e = 0; rs2_e = 0; rd_m = 0; reg_write_m = 1; rd_w = 0;
    #1 check("fwd_a_x0", fwd_a0, 2'b00);
    step();
    quiet_inputs();

    // Load-use hazard and its qualifiers
    load_use_setup();
    #1 check("lw_stall", {stall_f[0], stall_d[0], flush_e[0]}, 3'b111);
    step();
    rs2_used_d = 0;
    step();
    rs2_used_d = 1; rd_e = 0;
    #1 check("lw_rd_x0", stall_f[0], 1'b0);
    step();
    quiet_inputs();

    // Multi-cycle op held in E, then a back-to-back op
    md_op_e = 1;
    sf_run = 0;
    repeat (4) step();
    check("md_stall_cycles", sf_run, 3);
    sf_run = 0;
    repeat (4) step();
    check("md_b2b_cycles", sf_run, 3);
    quiet_inputs();
    step();

    // Memory wait at countdown 1 with a branch resolved during the wait
    md_op_e = 1;
    sf_run = 0;
    step();
    step();
    dmem_ready_m = 0; pc_src_e = 1;
    step();
    step();
    dmem_ready_m = 1; pc_src_e = 0;
    step();
    step();
    check("md_mem_cycles", sf_run, 5);
    quiet_inputs();
    step();

    // Branch coinciding with a load-use hazard
    load_use_setup();
    pc_src_e = 1;
    #1 check("br_lw", {stall_f[0], stall_d[0], flush_d[0], flush_e[0]}, 4'b1111);
    step();
    quiet_inputs();

    // Reset in the middle of a multi-cycle op
    md_op_e = 1;
    step();
    step();
    rst = 1;
    step();
    rst = 0; md_op_e = 0;
    #1 check("rst_busy", md_busy[0], 1'b0);
    check("rst_count", sc0, 4'd0);
    step();

    // Saturation of the 4-bit stall counter
    load_use_setup();
    repeat (20) step();
    check("count_sat", sc0, 4'd15);
    quiet_inputs();
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      rs1_d        = 5'($urandom_range(0, 7));
      rs2_d        = 5'($urandom_range(0, 7));
      rs1_used_d   = 1'($urandom);
      rs2_used_d   = 1'($urandom);
      rs1_e        = 5'($urandom_range(0, 7));
      rs2_e        = 5'($urandom_range(0, 7));
      rd_e         = 5'($urandom_range(0, 7));
      reg_write_e  = 1'($urandom);
      load_e       = ($urandom_range(0, 3) == 0);
      md_op_e      = ($urandom_range(0, 3) == 0);
      pc_src_e     = ($urandom_range(0, 7) == 0);
      rd_m         = 5'($urandom_range(0, 7));
      reg_write_m  = 1'($urandom);
      dmem_ready_m = ($urandom_range(0, 4) != 0);
      rd_w         = 5'($urandom_range(0, 7));
      reg_write_w  = 1'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
